// File: rtl/i2c_pkg.sv
// Shared I2C definitions: transmitter state encoding, SDA drive levels,
// ACK/NACK bit values and line-event strobes used by the tx and rx paths.
package i2c_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT    = 2'd1,
        ST_ACK_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } tx_state_t;

    localparam logic SDA_RELEASE   = 1'b1;
    localparam logic SDA_DRIVE_LOW = 1'b0;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    // Single-cycle strobes derived from the synchronised SCL/SDA lines
    typedef struct packed {
        logic scl_rise;
        logic scl_fall;
        logic bus_start;
        logic bus_stop;
    } line_evt_t;

    function automatic logic lead_bit(input logic [7:0] data, input logic lsb_first);
        return lsb_first ? data[0] : data[7];
    endfunction

    function automatic logic [7:0] shift_next(input logic [7:0] data, input logic lsb_first);
        return lsb_first ? {1'b0, data[7:1]} : {data[6:0], 1'b0};
    endfunction

    function automatic logic bit_to_sda(input logic b);
        return b ? SDA_RELEASE : SDA_DRIVE_LOW;
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchroniser producing registered edge and START/STOP strobes;
// shared between the slave transmit and receive paths.
module i2c_line_sync
    import i2c_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      scl,
    input  logic      sda,
    output logic      scl_s,
    output logic      sda_s,
    output line_evt_t evt
);

    logic [SYNC_STAGES-1:0] scl_pipe;
    logic [SYNC_STAGES-1:0] sda_pipe;
    logic                   scl_d;
    logic                   sda_d;

    assign scl_s = scl_pipe[SYNC_STAGES-1];
    assign sda_s = sda_pipe[SYNC_STAGES-1];

    // Lines reset to the idle-bus level so no event fires on reset release
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scl_pipe <= '1;
            sda_pipe <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
            evt      <= '0;
        end else begin
            scl_pipe      <= {scl_pipe[SYNC_STAGES-2:0], scl};
            sda_pipe      <= {sda_pipe[SYNC_STAGES-2:0], sda};
            scl_d         <= scl_s;
            sda_d         <= sda_s;
            evt.scl_rise  <= scl_s & ~scl_d;
            evt.scl_fall  <= ~scl_s & scl_d;
            evt.bus_start <= scl_s & scl_d & sda_d & ~sda_s;
            evt.bus_stop  <= scl_s & scl_d & ~sda_d & sda_s;
        end
    end

endmodule

// File: rtl/i2c_slave_tx_burst.sv
// Slave-side I2C read-burst transmitter: serialises fetched bytes onto SDA
// and collects the master's ACK/NACK after each one.
module i2c_slave_tx_burst
    import i2c_pkg::*;
#(
    parameter int unsigned  MAX_BYTES   = 16,
    parameter bit           LSB_FIRST   = 1'b0,
    parameter int unsigned  SYNC_STAGES = 2,
    localparam int unsigned CNT_W       = $clog2(MAX_BYTES + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] byte_count,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             scl,
    input  logic             sda_in,
    output logic             sda_out,
    output logic             busy,
    output logic             byte_done,
    output logic             finish,
    output logic             nack,
    output logic             underrun
);

    tx_state_t        state;
    logic [7:0]       shreg;
    logic [2:0]       bit_cnt;
    logic [CNT_W-1:0] bytes_left;
    logic             ack_bit;

    logic             scl_s;
    logic             sda_s;
    line_evt_t        evt;

    logic             count_ok;
    logic             start_ok;
    logic             in_burst;
    logic             abort;
    logic             fetch_next;
    logic [7:0]       fetch_byte;
    logic [7:0]       shifted;

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_sync (
        .clock(clock),
        .reset(reset),
        .scl  (scl),
        .sda  (sda_in),
        .scl_s(scl_s),
        .sda_s(sda_s),
        .evt  (evt)
    );

    assign count_ok   = (byte_count != '0) && (byte_count <= CNT_W'(MAX_BYTES));
    assign start_ok   = (state == ST_IDLE) && start && !scl_s && count_ok;
    assign in_burst   = (state == ST_SHIFT) || (state == ST_ACK_WAIT);
    assign abort      = in_burst && (evt.bus_start || evt.bus_stop);
    assign fetch_next = (state == ST_ACK_WAIT) && evt.scl_fall && !abort &&
                        (ack_bit == I2C_ACK) && (bytes_left != '0);

    // Byte handshake happens at burst start and at each ACKed byte boundary
    assign data_ready = start_ok || fetch_next;

    // A missing byte goes out as all-ones so SDA simply stays released
    assign fetch_byte = data_valid ? data_in : 8'hFF;
    assign shifted    = shift_next(shreg, LSB_FIRST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            bytes_left <= '0;
            ack_bit    <= I2C_ACK;
            sda_out    <= SDA_RELEASE;
            busy       <= 1'b0;
            byte_done  <= 1'b0;
            finish     <= 1'b0;
            nack       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            finish    <= 1'b0;

            case (state)
                ST_IDLE: begin
                    sda_out <= SDA_RELEASE;
                    if (start_ok) begin
                        shreg      <= fetch_byte;
                        bit_cnt    <= '0;
                        bytes_left <= byte_count - CNT_W'(1);
                        underrun   <= ~data_valid;
                        nack       <= 1'b0;
                        busy       <= 1'b1;
                        sda_out    <= bit_to_sda(lead_bit(fetch_byte, LSB_FIRST));
                        state      <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (abort) begin
                        sda_out <= SDA_RELEASE;
                        finish  <= 1'b1;
                        nack    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (evt.scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_out <= SDA_RELEASE;
                            state   <= ST_ACK_WAIT;
                        end else begin
                            shreg   <= shifted;
                            bit_cnt <= bit_cnt + 3'd1;
                            sda_out <= bit_to_sda(lead_bit(shifted, LSB_FIRST));
                        end
                    end
                end

                ST_ACK_WAIT: begin
                    if (abort) begin
                        sda_out <= SDA_RELEASE;
                        finish  <= 1'b1;
                        nack    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (evt.scl_rise) begin
                        ack_bit <= sda_s;
                    end else if (evt.scl_fall) begin
                        byte_done <= 1'b1;
                        if ((ack_bit == I2C_NACK) || (bytes_left == '0)) begin
                            finish  <= 1'b1;
                            nack    <= (ack_bit == I2C_NACK);
                            sda_out <= SDA_RELEASE;
                            state   <= ST_DONE;
                        end else begin
                            bytes_left <= bytes_left - CNT_W'(1);
                            bit_cnt    <= '0;
                            shreg      <= fetch_byte;
                            if (!data_valid) begin
                                underrun <= 1'b1;
                            end
                            sda_out <= bit_to_sda(lead_bit(fetch_byte, LSB_FIRST));
                            state   <= ST_SHIFT;
                        end
                    end
                end

                ST_DONE: begin
                    sda_out <= SDA_RELEASE;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end

                default: begin
                    sda_out <= SDA_RELEASE;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_tx_burst.sv
// Bench for i2c_slave_tx_burst: an I2C master model clocks randomised read
// bursts and compares bus traffic and status pulses to per-burst expectations.
module tb_i2c_slave_tx_burst;

    localparam int unsigned CNT_W = 5;
    localparam int unsigned SYNC  = 2;
    localparam int          HALF  = 12;
    localparam int          QTR   = 4;

    logic             clock;
    logic             reset;
    logic             start;
    logic             start_lsb;
    logic [CNT_W-1:0] byte_count;
    logic [7:0]       data_in;
    logic             data_valid;
    logic             scl;
    logic             master_sda;
    logic             sda_bus;

    logic data_ready, sda_out, busy, byte_done, finish, nack, underrun;
    logic data_ready_l, sda_out_l, busy_l, byte_done_l, finish_l, nack_l, underrun_l;

    int   checks;
    int   failures;
    int   n_ready, n_accept, n_done, n_finish;
    logic fin_nack;
    logic clr_mon;

    logic [7:0] bytes_q [8];
    logic       valid_q [8];

    // Open-drain bus: either side can pull low
    assign sda_bus = sda_out & master_sda;

    i2c_slave_tx_burst #(
        .MAX_BYTES  (16),
        .LSB_FIRST  (1'b0),
        .SYNC_STAGES(SYNC)
    ) u_dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .byte_count(byte_count),
        .data_in   (data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .scl       (scl),
        .sda_in    (sda_bus),
        .sda_out   (sda_out),
        .busy      (busy),
        .byte_done (byte_done),
        .finish    (finish),
        .nack      (nack),
        .underrun  (underrun)
    );

    i2c_slave_tx_burst #(
        .MAX_BYTES  (16),
        .LSB_FIRST  (1'b1),
        .SYNC_STAGES(SYNC)
    ) u_dut_lsb (
        .clock     (clock),
        .reset     (reset),
        .start     (start_lsb),
        .byte_count(byte_count),
        .data_in   (data_in),
        .data_valid(data_valid),
        .data_ready(data_ready_l),
        .scl       (scl),
        .sda_in    (sda_bus),
        .sda_out   (sda_out_l),
        .busy      (busy_l),
        .byte_done (byte_done_l),
        .finish    (finish_l),
        .nack      (nack_l),
        .underrun  (underrun_l)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pulse/handshake counters, sampled on the values of the cycle that is ending
    always @(posedge clock) begin
        if (clr_mon) begin
            n_ready  <= 0;
            n_accept <= 0;
            n_done   <= 0;
            n_finish <= 0;
            fin_nack <= 1'b0;
        end else begin
            if (data_ready) begin
                n_ready <= n_ready + 1;
                if (data_valid) n_accept <= n_accept + 1;
            end
            if (byte_done) n_done <= n_done + 1;
            if (finish) begin
                n_finish <= n_finish + 1;
                fin_nack <= nack;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Bus START from idle; returns a quarter period into SCL low
    task automatic bus_start_cond();
        clk(QTR);
        master_sda = 1'b0;
        clk(HALF);
        scl = 1'b0;
        clk(QTR);
        master_sda = 1'b1;
    endtask

    // Bus STOP, entered a quarter period into SCL low; leaves the bus idle
    task automatic stop_cond();
        master_sda = 1'b0;
        clk(HALF - QTR);
        scl = 1'b1;
        clk(QTR);
        master_sda = 1'b1;
        clk(HALF);
    endtask

    // One SCL clock, entered a quarter period into SCL low; samples SDA mid-high
    task automatic clock_bit(output logic b);
        clk(HALF - QTR);
        scl = 1'b1;
        clk(HALF / 2);
        b = sda_bus;
        clk(HALF - HALF / 2);
        scl = 1'b0;
        clk(QTR);
    endtask

    task automatic set_all_valid();
        for (int k = 0; k < 8; k++) valid_q[k] = 1'b1;
    endtask

    // Master reads a burst of n bytes, NACKing byte nack_at (<0 or >=n: never)
    task automatic run_burst(input int n, input int nack_at, input bit poke);
        int         sent;
        int         exp_acc;
        logic       exp_nack;
        logic       exp_unf;
        logic       b;
        logic [7:0] got;
        logic [7:0] exp;

        exp_nack = (nack_at >= 0) && (nack_at < n);
        sent     = exp_nack ? nack_at + 1 : n;
        exp_acc  = 0;
        exp_unf  = 1'b0;
        for (int k = 0; k < sent; k++) begin
            if (valid_q[k]) exp_acc++;
            else exp_unf = 1'b1;
        end

        clr_mon = 1'b1;
        clk(1);
        clr_mon = 1'b0;

        bus_start_cond();
        byte_count = CNT_W'(n);
        data_in    = bytes_q[0];
        data_valid = valid_q[0];
        start      = 1'b1;
        clk(1);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);

        for (int k = 0; k < sent; k++) begin
            got = '0;
            for (int i = 0; i < 8; i++) begin
                if (poke && k == 0 && i == 3) begin
                    start = 1'b1;
                    clk(1);
                    start = 1'b0;
                end
                clock_bit(b);
                got = {got[6:0], b};
            end
            exp = valid_q[k] ? bytes_q[k] : 8'hFF;
            check("bus_byte", 32'(got), 32'(exp));

            master_sda = (k == nack_at) ? 1'b1 : 1'b0;
            clk(HALF - QTR);
            if (k + 1 < 8) begin
                data_in    = bytes_q[k + 1];
                data_valid = valid_q[k + 1];
            end
            scl = 1'b1;
            clk(HALF / 2);
            check("ack_slot_released", 32'(sda_out), 32'd1);
            clk(HALF - HALF / 2);
            scl = 1'b0;
            clk(QTR);
            master_sda = 1'b1;
        end

        stop_cond();
        clk(4);
        check("byte_done_count", n_done, sent);
        check("finish_count", n_finish, 32'd1);
        check("nack_at_finish", 32'(fin_nack), 32'(exp_nack));
        check("ready_count", n_ready, sent);
        check("accept_count", n_accept, exp_acc);
        check("underrun", 32'(underrun), 32'(exp_unf));
        check("busy_end", 32'(busy), 32'd0);
        check("sda_end", 32'(sda_out), 32'd1);
    endtask

    initial begin
        int   n;
        int   nack_at;
        bit   poke;
        logic b;

        checks     = 0;
        failures   = 0;
        clr_mon    = 1'b1;
        reset      = 1'b1;
        start      = 1'b0;
        start_lsb  = 1'b0;
        byte_count = '0;
        data_in    = '0;
        data_valid = 1'b0;
        scl        = 1'b1;
        master_sda = 1'b1;
        set_all_valid();
        for (int k = 0; k < 8; k++) bytes_q[k] = 8'h00;

        clk(3);
        check("rst_sda", 32'(sda_out), 32'd1);
        check("rst_status", 32'({busy, byte_done, finish, nack, underrun}), 32'd0);
        reset = 1'b0;
        clk(SYNC + 3);
        check("idle_ready", 32'(data_ready), 32'd0);

        // Single byte, ACKed
        bytes_q[0] = 8'hA5;
        run_burst(1, -1, 1'b0);

        // Three bytes all ACKed, with a stray start while busy
        bytes_q[0] = 8'h01; bytes_q[1] = 8'h80; bytes_q[2] = 8'hFF;
        run_burst(3, -1, 1'b1);

        // Four requested, master NACKs the second
        for (int k = 0; k < 4; k++) bytes_q[k] = 8'($urandom);
        run_burst(4, 1, 1'b0);

        // Source not ready at the second byte boundary
        for (int k = 0; k < 3; k++) bytes_q[k] = 8'($urandom);
        valid_q[1] = 1'b0;
        run_burst(3, -1, 1'b0);
        set_all_valid();
        run_burst(2, -1, 1'b0);

        // STOP in the middle of the first byte while SDA is released
        clr_mon = 1'b1;
        clk(1);
        clr_mon = 1'b0;
        bytes_q[0] = 8'hFF;
        bus_start_cond();
        byte_count = CNT_W'(2);
        data_in    = 8'hFF;
        data_valid = 1'b1;
        start      = 1'b1;
        clk(1);
        start = 1'b0;
        clock_bit(b);
        clock_bit(b);
        master_sda = 1'b0;
        clk(HALF - QTR);
        scl = 1'b1;
        clk(QTR);
        master_sda = 1'b1;
        clk(SYNC + 2);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_sda", 32'(sda_out), 32'd1);
        clk(1);
        check("stop_finish", n_finish, 32'd1);
        check("stop_nack", 32'(fin_nack), 32'd1);
        clk(HALF);

        // Out-of-range burst lengths are ignored
        bus_start_cond();
        for (int t = 0; t < 2; t++) begin
            byte_count = (t == 0) ? CNT_W'(0) : CNT_W'(17);
            start = 1'b1;
            #1;
            check("bad_count_ready", 32'(data_ready), 32'd0);
            clk(1);
            start = 1'b0;
            clk(2);
            check("bad_count_busy", 32'(busy), 32'd0);
        end
        stop_cond();

        // Bit order per instance, then reset while driving low
        bus_start_cond();
        byte_count = CNT_W'(1);
        data_in    = 8'h01;
        data_valid = 1'b1;
        start      = 1'b1;
        start_lsb  = 1'b1;
        clk(1);
        start     = 1'b0;
        start_lsb = 1'b0;
        check("lsb_first_bit", 32'(sda_out_l), 32'd1);
        check("msb_first_bit", 32'(sda_out), 32'd0);
        clock_bit(b);
        clock_bit(b);
        check("pre_reset_drive", 32'(sda_out), 32'd0);
        reset = 1'b1;
        #1;
        check("reset_sda_async", 32'(sda_out), 32'd1);
        check("reset_busy_async", 32'(busy), 32'd0);
        check("lsb_reset", 32'({data_ready_l, busy_l, byte_done_l, finish_l, nack_l, underrun_l, sda_out_l}),
              32'd1);
        clk(2);
        scl        = 1'b1;
        master_sda = 1'b1;
        clk(2);
        reset = 1'b0;
        clk(SYNC + 3);

        // Randomised bursts
        for (int it = 0; it < 10; it++) begin
            n = int'($urandom_range(1, 6));
            for (int k = 0; k < 8; k++) begin
                bytes_q[k] = 8'($urandom);
                valid_q[k] = ($urandom_range(0, 4) != 0);
            end
            if ($urandom_range(0, 1) == 0) nack_at = -1;
            else nack_at = int'($urandom_range(0, n - 1));
            poke = ($urandom_range(0, 1) == 1);
            run_burst(n, nack_at, poke);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
